id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Instruction-decode stage of the 16-bit processor. Holds the 8x16 general register file,
//  provides two combinational read ports addressed by rs/rt, and writes back dataToWrite
//  to rt or rd. Sign-extends the 6-bit immediate to 16 bits. Sits between IF and EX.
// PARAMETERS
//  DATA_W   16  register/data width
//  REG_N    8   number of registers (address width = 3)
//  IMM_W    6   immediate field width before extension
// PORTS
//  clock          in   1   single clock; all state updates on rising edge
//  reset_n        in   1   synchronous, active-low reset
//  rs             in   3   read address port 1 (instr[11:9])
//  rt             in   3   read address port 2 / write address when RegDst=0 (instr[8:6])
//  rd             in   3   write address when RegDst=1 (instr[5:3])
//  funct          in   3   function field (instr[2:0]); carried in, not decoded here
//  signalToExtend in   6   immediate field (instr[5:0])
//  dataToWrite    in   16  write-back data
//  RegWrite       in   1   1 = write register file at next rising edge
//  RegDst         in   1   write-address select: 0 = rt, 1 = rd
//  readData1      out  16  contents of register rs
//  readData2      out  16  contents of register rt
//  extendedSignal out  16  {{10{signalToExtend[5]}}, signalToExtend}
// BEHAVIOUR
//  - Reset: when reset_n=0 at a rising edge, all 8 registers clear to 16'h0000; reset beats
//    any simultaneous write. Outputs then read 0 (combinational from cleared regs).
//  - Write: at rising edge with reset_n=1 and RegWrite=1, reg[RegDst ? rd : rt] <= dataToWrite.
//    RegWrite=0: no state change regardless of other inputs. Write latency 1 clock.
//  - r0 hardwired zero: writes to address 0 are discarded; reads of r0 always return 0.
//  - Reads: readData1/readData2 are purely combinational from rs/rt; 0 cycle latency.
//    Both ports may address the same register and return identical data.
//  - Read-during-write (same address, same cycle): read returns OLD value unless
//    ID_BYPASS_EN is defined (see CONFIGURATION).
//  - extendedSignal: combinational; bit 5 replicated into bits 15:6; independent of reset.
//  - RegDst/rd/rt are ignored when RegWrite=0. X on unused inputs must not corrupt state.
//  - No handshake; stage is always ready.
// CONFIGURATION
//  ID_BYPASS_EN defined: write-through forwarding - if RegWrite=1, reset_n=1, write addr!=0
//    and write addr equals rs (rt), readData1 (readData2) returns dataToWrite in same cycle.
//  ID_BYPASS_EN undefined: reads always reflect stored register contents only.
// STRUCTURE
//  - Shared package: DATA_W, REG_ADDR_W=3, IMM_W, field bit positions (RS/RT/RD/FUNCT/IMM lsb/msb).
//  - Sub-module id_regfile: 8x16 storage, sync reset, one write port, two async read ports,
//    r0 zero, optional bypass. id_stage adds RegDst mux and sign extender.
// TESTING
//  1. reset_n=0 one edge, RegWrite=0, instr 16'h22BA (rs=1,rt=2,rd=7,imm=6'b111010)
//     -> readData1=0, readData2=0, extendedSignal=16'hFFFA.
//  2. RegWrite=1, RegDst=1, rd=7, dataToWrite=16'h31EB, one edge; then rs=7
//     -> readData1=16'h31EB; reg rt=2 unchanged (0).
//  3. RegWrite=1, RegDst=0, rt=2, dataToWrite=16'hA5A5, one edge -> readData2=16'hA5A5,
//     rd register 7 still 16'h31EB.
//  4. RegWrite=1, rd=0, RegDst=1, dataToWrite=16'hFFFF -> reading r0 gives 16'h0000.
//  5. signalToExtend=6'b011111 -> 16'h001F; 6'b100000 -> 16'hFFE0; RegWrite=0 with
//     dataToWrite changing -> no register changes.
//  6. Regs loaded, reset_n=0 with RegWrite=1 on same edge -> all regs 0; with ID_BYPASS_EN,
//     rs=rt=3 write 16'h1234 -> readData1=readData2=16'h1234 before the edge.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared widths, instruction field positions and write-request type for the ID stage.
// Optional feature macro used by the design: ID_BYPASS_EN (write-through forwarding).
package id_stage_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_N      = 8;
    localparam int REG_ADDR_W = 3;
    localparam int IMM_W      = 6;

    // Instruction field positions (16-bit instruction word)
    localparam int RS_MSB    = 11;
    localparam int RS_LSB    = 9;
    localparam int RT_MSB    = 8;
    localparam int RT_LSB    = 6;
    localparam int RD_MSB    = 5;
    localparam int RD_LSB    = 3;
    localparam int FUNCT_MSB = 2;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 5;
    localparam int IMM_LSB   = 0;

    typedef enum logic {
        DST_RT = 1'b0,
        DST_RD = 1'b1
    } reg_dst_e;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wr_req_t;

    function automatic logic [DATA_W-1:0] sign_extend(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/id_regfile.sv
// 8x16 register file: synchronous active-low reset, one write port, two async read ports.
// r0 reads as zero and ignores writes; ID_BYPASS_EN adds same-cycle write-through forwarding.
module id_regfile
    import id_stage_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  wr_req_t               i_wr,
    input  logic [REG_ADDR_W-1:0] i_raddr1,
    input  logic [REG_ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0]     o_rdata1,
    output logic [DATA_W-1:0]     o_rdata2
);

    logic [DATA_W-1:0] r_regs [0:REG_N-1];
    logic              w_wr_hit;
    logic              w_fwd1;
    logic              w_fwd2;
    logic [DATA_W-1:0] w_stored1;
    logic [DATA_W-1:0] w_stored2;

    // Address 0 is never written, so a write there cannot disturb anything.
    assign w_wr_hit = i_wr.we && (i_wr.addr != '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < REG_N; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_hit) begin
            r_regs[i_wr.addr] <= i_wr.data;
        end
    end

    assign w_stored1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
    assign w_stored2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];

`ifdef ID_BYPASS_EN
    // Forward only writes that will actually land at the coming edge.
    assign w_fwd1 = w_wr_hit && i_rst_n && (i_wr.addr == i_raddr1);
    assign w_fwd2 = w_wr_hit && i_rst_n && (i_wr.addr == i_raddr2);
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    assign o_rdata1 = w_fwd1 ? i_wr.data : w_stored1;
    assign o_rdata2 = w_fwd2 ? i_wr.data : w_stored2;

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: register file, RegDst write-address mux and immediate sign extender.
// Build option: define ID_BYPASS_EN for same-cycle write-through forwarding on both read ports.
module id_stage
    import id_stage_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [2:0]            funct,
    input  logic [IMM_W-1:0]      signalToExtend,
    input  logic [DATA_W-1:0]     dataToWrite,
    input  logic                  RegWrite,
    input  logic                  RegDst,
    output logic [DATA_W-1:0]     readData1,
    output logic [DATA_W-1:0]     readData2,
    output logic [DATA_W-1:0]     extendedSignal
);

    wr_req_t w_wr;
    logic    w_unused_funct;

    // funct travels with the instruction to EX; nothing here decodes it.
    assign w_unused_funct = ^funct;

    always_comb begin
        w_wr      = '0;
        w_wr.we   = RegWrite;
        w_wr.addr = (reg_dst_e'(RegDst) == DST_RD) ? rd : rt;
        w_wr.data = dataToWrite;
    end

    id_regfile u_regfile (
        .i_clk    (clock),
        .i_rst_n  (reset_n),
        .i_wr     (w_wr),
        .i_raddr1 (rs),
        .i_raddr2 (rt),
        .o_rdata1 (readData1),
        .o_rdata2 (readData2)
    );

    assign extendedSignal = sign_extend(signalToExtend);

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: scoreboard queue of expected outputs, immediate-assertion checks.
module tb_id_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  rs, rt, rd, funct;
    logic [5:0]  signalToExtend;
    logic [15:0] dataToWrite;
    logic        RegWrite, RegDst;
    logic [15:0] readData1, readData2, extendedSignal;

    id_stage dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .funct          (funct),
        .signalToExtend (signalToExtend),
        .dataToWrite    (dataToWrite),
        .RegWrite       (RegWrite),
        .RegDst         (RegDst),
        .readData1      (readData1),
        .readData2      (readData2),
        .extendedSignal (extendedSignal)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        int          sel;   // 0 = readData1, 1 = readData2, 2 = extendedSignal
        logic [15:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    logic [15:0] m_regs [0:7];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic sb_push(input string tag, input int sel, input logic [15:0] exp);
        sb_t e;
        e.tag = tag; e.sel = sel; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_drain();
        sb_t         e;
        logic [15:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                0:       obs = readData1;
                1:       obs = readData2;
                default: obs = extendedSignal;
            endcase
            n_cmp++;
            assert (obs === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    // One write through the port selected by dst; the unused address field gets noise.
    task automatic wr(input logic dst, input logic [2:0] a, input logic [15:0] d);
        RegWrite    = 1'b1;
        RegDst      = dst;
        dataToWrite = d;
        if (dst) begin rd = a; rt = 3'($urandom); end
        else     begin rt = a; rd = 3'($urandom); end
        @(posedge clock); #1;
        RegWrite = 1'b0;
        if (a != 3'd0) m_regs[a] = d;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [2:0] b);
        rs = a; rt = b;
        #1;
        sb_push({tag, "_rd1"}, 0, m_regs[a]);
        sb_push({tag, "_rd2"}, 1, m_regs[b]);
        sb_drain();
    endtask

    task automatic ext_chk(input string tag, input logic [5:0] v, input logic [15:0] exp);
        signalToExtend = v;
        #1;
        sb_push(tag, 2, exp);
        sb_drain();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;

        // Step 1: reset with instruction 16'h22BA on the fields
        reset_n = 1'b0; RegWrite = 1'b0; RegDst = 1'b0;
        rs = 3'd1; rt = 3'd2; rd = 3'd7; funct = 3'd2;
        signalToExtend = 6'b111010; dataToWrite = 16'h0000;
        @(posedge clock); #1;
        sb_push("rst_rd1", 0, 16'h0000);
        sb_push("rst_rd2", 1, 16'h0000);
        sb_push("rst_ext", 2, 16'hFFFA);
        sb_drain();
        reset_n = 1'b1;

        // Step 2: write via rd
        wr(1'b1, 3'd7, 16'h31EB);
        rs = 3'd7; rt = 3'd2; #1;
        sb_push("wr_rd_r7", 0, 16'h31EB);
        sb_push("wr_rd_r2", 1, 16'h0000);
        sb_drain();

        // Step 3: write via rt
        wr(1'b0, 3'd2, 16'hA5A5);
        rs = 3'd7; rt = 3'd2; #1;
        sb_push("wr_rt_r7", 0, 16'h31EB);
        sb_push("wr_rt_r2", 1, 16'hA5A5);
        sb_drain();

        // Step 4: r0 ignores writes
        wr(1'b1, 3'd0, 16'hFFFF);
        rs = 3'd0; rt = 3'd0; #1;
        sb_push("r0_rd1", 0, 16'h0000);
        sb_push("r0_rd2", 1, 16'h0000);
        sb_drain();

        // Step 5: sign extension boundaries and a small sweep
        ext_chk("ext_pos_max", 6'b011111, 16'h001F);
        ext_chk("ext_neg_min", 6'b100000, 16'hFFE0);
        ext_chk("ext_zero",    6'b000000, 16'h0000);
        ext_chk("ext_all1",    6'b111111, 16'hFFFF);

        // RegWrite=0 with changing data and X on the write-address inputs
        RegWrite = 1'b0; RegDst = 1'bx; rd = 3'bxxx;
        for (int k = 0; k < 3; k++) begin
            dataToWrite = 16'h1111 * 16'(k + 1);
            @(posedge clock); #1;
        end
        RegDst = 1'b0; rd = 3'd0;
        rd_chk("nowr_a", 3'd7, 3'd2);
        rd_chk("nowr_b", 3'd1, 3'd3);

        // Load every register, then read back all pairs
        for (int i = 1; i < 8; i++) wr(i[0], i[2:0], 16'($urandom));
        for (int a = 0; a < 8; a++) rd_chk("sweep", a[2:0], 3'(7 - a));
        rd_chk("same_addr", 3'd5, 3'd5);

        // Read-during-write on r3
        wr(1'b0, 3'd3, 16'h0BAD);
        rs = 3'd3; rt = 3'd3; RegDst = 1'b0; dataToWrite = 16'h1234; RegWrite = 1'b1;
        #1;
`ifdef ID_BYPASS_EN
        sb_push("rdw_rd1", 0, 16'h1234);
        sb_push("rdw_rd2", 1, 16'h1234);
`else
        sb_push("rdw_rd1", 0, 16'h0BAD);
        sb_push("rdw_rd2", 1, 16'h0BAD);
`endif
        sb_drain();
        @(posedge clock); #1;
        RegWrite = 1'b0;
        m_regs[3] = 16'h1234;
        rd_chk("rdw_after", 3'd3, 3'd3);

        // Same-cycle write to r0 is never forwarded
        rs = 3'd0; rt = 3'd4; RegDst = 1'b1; rd = 3'd0; dataToWrite = 16'hFFFF; RegWrite = 1'b1;
        #1;
        sb_push("r0_nofwd", 0, 16'h0000);
        sb_drain();
        @(posedge clock); #1;
        RegWrite = 1'b0;
        rd_chk("r0_after", 3'd0, 3'd4);

        // Step 6: reset beats a simultaneous write (and is not forwarded)
        reset_n = 1'b0; RegWrite = 1'b1; RegDst = 1'b1; rd = 3'd5; dataToWrite = 16'hBEEF;
        rs = 3'd5; rt = 3'd6;
        #1;
        sb_push("rst_wr_nofwd", 0, m_regs[5]);
        sb_drain();
        @(posedge clock); #1;
        reset_n = 1'b1; RegWrite = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        for (int a = 0; a < 8; a++) rd_chk("post_rst", a[2:0], 3'(7 - a));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
